debug_bus_arbiter: RTL and testbench

//  Arbitrates NUM_REQ requesters for the Debugger Module's shared tristate data bus.

---
 rtl/debug_bus_arbiter_pkg.sv | 17 +
 rtl/debug_bus_arbiter_rr_picker.sv | 32 +++
 rtl/debug_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_debug_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_bus_arbiter_pkg.sv
// Shared types and defaults for the debug bus arbiter and related Debugger Module controllers.
package debug_bus_arbiter_pkg;

    localparam int unsigned DBG_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } arb_state_e;

    // Increment an index modulo n.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/debug_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping around.
module rr_priority_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner_c,
    output logic [IW-1:0]      winner_idx_c,
    output logic               any_c
);

    int unsigned cand;
    logic        found;

    always_comb begin
        winner_c     = '0;
        winner_idx_c = '0;
        found        = 1'b0;
        cand         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[IW'(cand)]) begin
                found                = 1'b1;
                winner_c[IW'(cand)]  = 1'b1;
                winner_idx_c         = IW'(cand);
            end
        end
        any_c = |req;
    end

endmodule

// File: rtl/debug_bus_arbiter.sv
// Round-robin owner arbitration for the Debugger Module's shared tristate data bus,
// with a hold timeout and an all-off turnaround between owners.
module debug_bus_arbiter
    import debug_bus_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = DBG_NUM_REQ,
    parameter  int unsigned MAX_HOLD   = 16,
    parameter  int unsigned TURNAROUND = 1,
    localparam int unsigned IW         = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] drive_en,
    output logic [IW-1:0]      grant_id,
    output logic               bus_busy,
    output logic               timeout
);

    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam int unsigned TW = $clog2(TURNAROUND + 1);

    arb_state_e         state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [TW-1:0]      turn_q, turn_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_d, drive_d;
    logic [IW-1:0]      grant_id_d;
    logic               busy_d, timeout_d;
    logic               take;

    logic [NUM_REQ-1:0] win_oh_c;
    logic [IW-1:0]      win_idx_c;
    logic               win_any_c;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req          (req),
        .ptr          (ptr_q),
        .winner_c     (win_oh_c),
        .winner_idx_c (win_idx_c),
        .any_c        (win_any_c)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        turn_d     = turn_q;
        ptr_d      = ptr_q;
        grant_d    = grant;
        drive_d    = drive_en;
        grant_id_d = grant_id;
        busy_d     = bus_busy;
        timeout_d  = 1'b0;
        take       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                take = win_any_c;
            end
            ST_OWN: begin
                if ((req & grant) == '0) begin
                    state_d = ST_TURN;
                    turn_d  = '0;
                    grant_d = '0;
                    drive_d = '0;
                end else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    if ((req & ~grant) != '0) begin
                        state_d   = ST_TURN;
                        turn_d    = '0;
                        grant_d   = '0;
                        drive_d   = '0;
                        timeout_d = 1'b1;
                    end else begin
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_TURN: begin
                if (turn_q == TW'(TURNAROUND - 1)) begin
                    if (win_any_c) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                drive_d = '0;
                busy_d  = 1'b0;
            end
        endcase

        // Hand the bus to the picker's winner; the just-released owner sits last in the search.
        if (take) begin
            state_d    = ST_OWN;
            hold_d     = '0;
            grant_d    = win_oh_c;
            drive_d    = win_oh_c;
            grant_id_d = win_idx_c;
            ptr_d      = IW'(wrap_inc(32'(win_idx_c), NUM_REQ));
            busy_d     = 1'b1;
        end
    end

    // State and output registers; async reset floats the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            turn_q   <= '0;
            ptr_q    <= '0;
            grant    <= '0;
            drive_en <= '0;
            grant_id <= '0;
            bus_busy <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            turn_q   <= turn_d;
            ptr_q    <= ptr_d;
            grant    <= grant_d;
            drive_en <= drive_d;
            grant_id <= grant_id_d;
            bus_busy <= busy_d;
            timeout  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Scoreboard bench for debug_bus_arbiter: directed scenarios plus random requests
// checked cycle by cycle against a behavioural ownership model.
module tb_debug_bus_arbiter;

    localparam int NR = 4;
    localparam int MH = 16;
    localparam int TA = 1;
    localparam int STARVE_BOUND = NR * (MH + TA);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] grant, drive_en;
    logic [1:0]    grant_id;
    logic          bus_busy, timeout;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    debug_bus_arbiter #(.NUM_REQ(NR), .MAX_HOLD(MH), .TURNAROUND(TA)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .drive_en (drive_en),
        .grant_id (grant_id),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [NR-1:0] g;
        logic [NR-1:0] d;
        logic [1:0]    id;
        logic          busy;
        logic          to;
    } exp_t;

    exp_t sb[$];
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_gap   = 0;
    int   m_last  = NR - 1;
    int   m_id    = 0;
    bit   m_to;
    logic [NR-1:0] m_mask;
    exp_t m_e;

    // Winner is the requester nearest after the last owner, going upward with wrap.
    function automatic int rr_pick(input logic [NR-1:0] r, input int last);
        int best = -1;
        int bestd = NR;
        for (int j = 0; j < NR; j++) begin
            if (r[2'(j)] && ((j - last - 1 + NR) % NR) < bestd) begin
                bestd = (j - last - 1 + NR) % NR;
                best  = j;
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_last = NR - 1; m_id = 0;
            sb.delete();
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                m_mask = NR'(1) << m_owner;
                if ((req & m_mask) == '0) begin
                    m_owner = -1; m_gap = TA;
                end else if (m_held == MH) begin
                    if ((req & ~m_mask) != '0) begin
                        m_owner = -1; m_gap = TA; m_to = 1'b1;
                    end else begin
                        m_held = 1;
                    end
                end else begin
                    m_held++;
                end
            end else if (m_gap > 1) begin
                m_gap--;
            end else begin
                m_gap = 0;
                if (req != '0) begin
                    m_owner = rr_pick(req, m_last);
                    m_last  = m_owner;
                    m_id    = m_owner;
                    m_held  = 1;
                end
            end
            m_e.g    = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
            m_e.d    = m_e.g;
            m_e.id   = 2'(m_id);
            m_e.busy = (m_owner >= 0) || (m_gap > 0);
            m_e.to   = m_to;
            sb.push_back(m_e);
        end
    end

    // ---------------- monitor ----------------
    exp_t          mon_e;
    logic [NR-1:0] last_nz = '0;
    int            zero_run = 0;
    int            wait_c[NR];
    int            max_wait = 0;

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("scoreboard", 32'({grant, drive_en, grant_id, bus_busy, timeout}), 32'(mon_e));
            end
            check("onehot0", 32'($onehot0(drive_en)), 32'd1);
            check("en_within_grant", 32'(drive_en & ~grant), 32'd0);
            if (drive_en != '0) begin
                if (last_nz != '0 && drive_en != last_nz)
                    check("turn_gap", 32'(zero_run >= TA), 32'd1);
                last_nz  = drive_en;
                zero_run = 0;
            end else begin
                zero_run++;
            end
            for (int i = 0; i < NR; i++) begin
                if (req[2'(i)] && !grant[2'(i)]) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end
        end else begin
            last_nz  = '0;
            zero_run = 0;
            for (int i = 0; i < NR; i++) wait_c[i] = 0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    int owners[$];
    int gaps[$];
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int cur, own_cnt, zrun, own0, bad, tos;
    logic to_seen;

    initial begin
        do_reset();
        check("reset_state", 32'({grant, drive_en, grant_id, bus_busy, timeout}), 32'd0);

        // Reset in the middle of an ownership
        req = 4'b0010;
        tick(); tick();
        check("own_before_rst", 32'({grant, drive_en}), 32'({4'b0010, 4'b0010}));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_drive", 32'(drive_en), 32'd0);
        check("rst_async_all", 32'({grant, grant_id, bus_busy, timeout}), 32'd0);
        repeat (2) begin
            tick();
            check("rst_hold", 32'({grant, drive_en, grant_id, bus_busy, timeout}), 32'd0);
        end
        req = '0;
        rst_n = 1'b1;
        tick();

        // Single requester: grant one cycle after req, bus free two cycles after drop
        do_reset();
        req = 4'b0001;
        tick();
        check("single_grant", 32'({grant, drive_en}), 32'({4'b0001, 4'b0001}));
        repeat (4) tick();
        req = '0;
        tick();
        check("single_drop_drive", 32'({drive_en, bus_busy}), 32'({4'b0000, 1'b1}));
        tick();
        check("single_idle", 32'(bus_busy), 32'd0);

        // Round robin: every owner drops after two cycles, others keep requesting
        do_reset();
        req = 4'b1111;
        cur = -1; own_cnt = 0; zrun = 0;
        for (int c = 0; c < 100 && owners.size() < 5; c++) begin
            tick();
            if (drive_en != '0) begin
                if ($clog2(drive_en) != cur) begin
                    if (owners.size() > 0) gaps.push_back(zrun);
                    cur = $clog2(drive_en);
                    owners.push_back(cur);
                    own_cnt = 0;
                end
                own_cnt++;
                zrun = 0;
                if (own_cnt == 2) req = req & ~drive_en;
            end else begin
                zrun++;
                cur = -1;
                req = 4'b1111;
            end
        end
        check("rr_count", 32'(owners.size()), 32'd5);
        for (int k = 0; k < owners.size() && k < 5; k++) check("rr_owner", 32'(owners[k]), 32'(rr_exp[k]));
        foreach (gaps[k]) check("rr_gap", 32'(gaps[k]), 32'(TA));
        req = '0;
        repeat (3) tick();

        // Timeout: owner 0 forcibly released after MAX_HOLD cycles while 1 waits
        do_reset();
        req = 4'b0011;
        own0 = 0; to_seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (drive_en == 4'b0001) own0++;
            else if (own0 > 0) begin
                to_seen = timeout;
                break;
            end
        end
        check("to_hold_len", 32'(own0), 32'(MH));
        check("to_pulse", 32'(to_seen), 32'd1);
        tick();
        check("to_next_owner", 32'({drive_en, timeout}), 32'({4'b0010, 1'b0}));
        req = '0;
        repeat (3) tick();

        // No competitor: continuous ownership, no timeout
        do_reset();
        req = 4'b0100;
        bad = 0; tos = 0;
        repeat (40) begin
            tick();
            if (drive_en != 4'b0100) bad++;
            if (timeout) tos++;
        end
        check("solo_continuous", 32'(bad), 32'd0);
        check("solo_no_timeout", 32'(tos), 32'd0);
        req = '0;
        repeat (3) tick();

        // Random traffic; each request line toggles rarely so holds and timeouts occur
        do_reset();
        repeat (10000) begin
            for (int i = 0; i < NR; i++)
                if ($urandom_range(15) == 0) req[2'(i)] = ~req[2'(i)];
            tick();
        end
        req = '0;
        repeat (5) tick();
        check("no_starvation", 32'(max_wait <= STARVE_BOUND), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
